// File: rtl/seg_scan.sv
// ---------------------------------------------------------------------------
// seg_scan
//   Time-multiplexed scanner for a 7-segment digit bank. Once per frame the
//   digit value, dot, blank and leading-zero controls are snapshotted. Each
//   digit then gets one slot of CLK_DIV cycles. The first BLANK_CYCLES cycles
//   of a slot keep every strobe dark so the previous digit cannot ghost into
//   the next one. The nibble and dot for the downstream hex decoder change on
//   the slot boundary, so they are already settled when the strobe turns on.
//
// Ports
//   clk         in   system clock (single domain)
//   reset_n     in   asynchronous assert, active-low reset
//   value       in   4*NUM_DIGITS  hex digits, digit i = value[4i+3:4i]
//   dots        in   NUM_DIGITS    decimal point request per digit
//   blank_mask  in   NUM_DIGITS    1 forces digit i dark
//   lz_en       in   1             1 suppresses leading zeros
//   data        out  4             nibble for the downstream decoder
//   dot         out  1             dot for the downstream decoder (active-high)
//   digit_sel   out  NUM_DIGITS    one-hot digit strobe, polarity per DIG_ACTIVE_LOW
//   frame_start out  1             one-cycle pulse as the digit 0 slot begins
// ---------------------------------------------------------------------------
module seg_scan #(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dots,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_en,
  output logic [3:0]              data,
  output logic                    dot,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF =
    (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_snapValue;
  logic [NUM_DIGITS-1:0]   r_snapDots;
  logic [NUM_DIGITS-1:0]   r_snapBlank;
  logic                    r_snapLz;
  logic [3:0]              r_data;
  logic                    r_dot;
  logic [NUM_DIGITS-1:0]   r_digitSel;
  logic                    r_frameStart;

  logic                    w_wrap;
  logic                    w_frame;
  logic [CW-1:0]           w_nextCnt;
  logic [IW-1:0]           w_nextIdx;
  logic [4*NUM_DIGITS-1:0] w_srcValue;
  logic [NUM_DIGITS-1:0]   w_srcDots;
  logic [NUM_DIGITS-1:0]   w_srcBlank;
  logic                    w_srcLz;
  logic [NUM_DIGITS-1:0]   w_lzRun;
  logic                    w_digitDark;
  logic [3:0]              w_nextNibble;
  logic [NUM_DIGITS-1:0]   w_nextSel;

  assign w_wrap  = (r_cnt == LAST_CNT);
  assign w_frame = w_wrap && (r_idx == LAST_IDX);

  // On the frame-boundary edge the live inputs are the ones being captured,
  // so digit 0 is taken straight from them to avoid a one-frame lag.
  assign w_srcValue = w_frame ? value      : r_snapValue;
  assign w_srcDots  = w_frame ? dots       : r_snapDots;
  assign w_srcBlank = w_frame ? blank_mask : r_snapBlank;
  assign w_srcLz    = w_frame ? lz_en      : r_snapLz;

  // w_lzRun[j] is set when digit j and every digit above it are zero.
  for (genvar j = 0; j < NUM_DIGITS; j++) begin : g_lzRun
    assign w_lzRun[j] = ~|w_srcValue[4*NUM_DIGITS-1:4*j];
  end

  // Next-state logic: slot counter, digit index, blank/show phase and the
  // values the registered outputs take on the coming edge. Everything is
  // evaluated for the slot the next edge lands in.
  always_comb begin
    w_nextCnt    = w_wrap ? '0 : r_cnt + CW'(1);
    w_nextIdx    = r_idx;
    w_nextState  = r_state;
    w_digitDark  = 1'b0;
    w_nextNibble = 4'h0;
    w_nextSel    = SEL_OFF;

    if (w_wrap) begin
      w_nextIdx = (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
    end

    case (r_state)
      ST_BLANK: begin
        if (int'(r_cnt) == BLANK_CYCLES - 1) begin
          w_nextState = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (w_wrap && (BLANK_CYCLES > 0)) begin
          w_nextState = ST_BLANK;
        end
      end
      default: w_nextState = ST_SHOW;
    endcase

    // Digit 0 is never leading-zero suppressed, so a zero value still shows "0".
    w_digitDark = w_srcBlank[w_nextIdx] ||
                  (w_srcLz && (w_nextIdx != '0) && w_lzRun[w_nextIdx]);

    w_nextNibble = w_srcValue[{w_nextIdx, 2'b00} +: 4];

    if ((w_nextState == ST_SHOW) && !w_digitDark) begin
      w_nextSel = SEL_OFF ^ (NUM_DIGITS'(1) << w_nextIdx);
    end
  end

  // State and output registers. Reset parks the scan on the last cycle of the
  // last digit so the first edge after release is a frame boundary, and turns
  // every strobe off immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= LAST_CNT;
      r_idx        <= LAST_IDX;
      r_state      <= ST_SHOW;
      r_snapValue  <= '0;
      r_snapDots   <= '0;
      r_snapBlank  <= '0;
      r_snapLz     <= 1'b0;
      r_data       <= 4'h0;
      r_dot        <= 1'b0;
      r_digitSel   <= SEL_OFF;
      r_frameStart <= 1'b0;
    end else begin
      r_cnt        <= w_nextCnt;
      r_idx        <= w_nextIdx;
      r_state      <= w_nextState;
      r_frameStart <= w_frame;
      r_digitSel   <= w_nextSel;
      if (w_frame) begin
        r_snapValue <= value;
        r_snapDots  <= dots;
        r_snapBlank <= blank_mask;
        r_snapLz    <= lz_en;
      end
      if (w_wrap) begin
        r_data <= w_nextNibble;
        r_dot  <= w_srcDots[w_nextIdx];
      end
    end
  end

  assign data        = r_data;
  assign dot         = r_dot;
  assign digit_sel   = r_digitSel;
  assign frame_start = r_frameStart;

endmodule

// File: tb/tb_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_seg_scan
//   Self-checking bench for seg_scan with NUM_DIGITS=4, CLK_DIV=8,
//   BLANK_CYCLES=2, active-low strobes. A frame-level reference model
//   predicts every output from the number of edges since reset release.
// ---------------------------------------------------------------------------
module tb_seg_scan;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = N * DIV;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dots = 4'h0;
  logic [3:0]  blankMask = 4'h0;
  logic        lzEn = 1'b0;
  logic [3:0]  data;
  logic        dot;
  logic [3:0]  digitSel;
  logic        frameStart;

  int checks = 0;
  int errors = 0;

  // Reference model: position within the scan since release (-1 = reset)
  // and the inputs captured at the latest frame boundary.
  int          p = -1;
  logic [15:0] mValue = 16'h0;
  logic [3:0]  mDots = 4'h0;
  logic [3:0]  mBlank = 4'h0;
  logic        mLz = 1'b0;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dots;
    logic [3:0]  blank;
    logic        lz;
    logic [3:0]  litMask;
  } vec_t;

  vec_t vecs[6];

  seg_scan #(
    .NUM_DIGITS(N),
    .CLK_DIV(DIV),
    .BLANK_CYCLES(BLANK),
    .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .value(value),
    .dots(dots),
    .blank_mask(blankMask),
    .lz_en(lzEn),
    .data(data),
    .dot(dot),
    .digit_sel(digitSel),
    .frame_start(frameStart)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Runaway guard so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t p=%0d: got %0h expected %0h", name, $time, p, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d,
                               input logic [3:0] b, input logic lz);
    value     = v;
    dots      = d;
    blankMask = b;
    lzEn      = lz;
  endtask

  // Predicts all outputs from the model position and compares them.
  task automatic modelCheck();
    int slot, cnt;
    logic dark;
    logic [3:0] expSel, expData;
    logic expDot, expFs;
    if (p < 0) begin
      expSel = 4'hF; expData = 4'h0; expDot = 1'b0; expFs = 1'b0;
    end else begin
      slot    = (p / DIV) % N;
      cnt     = p % DIV;
      dark    = mBlank[slot] || (mLz && slot != 0 && (mValue >> (4 * slot)) == 16'h0);
      expSel  = (cnt >= BLANK && !dark) ? ~(4'b0001 << slot) : 4'hF;
      expData = 4'((mValue >> (4 * slot)) & 16'hF);
      expDot  = mDots[slot];
      expFs   = (p % FRAME == 0);
    end
    checkOutput("digit_sel", 32'(digitSel), 32'(expSel));
    checkOutput("data", 32'(data), 32'(expData));
    checkOutput("dot", 32'(dot), 32'(expDot));
    checkOutput("frame_start", 32'(frameStart), 32'(expFs));
  endtask

  // One clock: advance the model on the edge, compare 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      p++;
      if (p % FRAME == 0) begin
        mValue = value; mDots = dots; mBlank = blankMask; mLz = lzEn;
      end
    end
    #1;
    modelCheck();
  endtask

  // Advance until the next edge will be a frame boundary.
  task automatic runToBoundary();
    for (int i = 0; i < FRAME && (p % FRAME) != FRAME - 1; i++) tick();
  endtask

  // Apply one table vector for a full frame and check strobe width per slot.
  task automatic runVector(input vec_t v);
    int onCount[N];
    int slot;
    for (int s = 0; s < N; s++) onCount[s] = 0;
    runToBoundary();
    applyStimulus(v.value, v.dots, v.blank, v.lz);
    for (int c = 0; c < FRAME; c++) begin
      tick();
      slot = (p / DIV) % N;
      if (digitSel[slot] == 1'b0) onCount[slot]++;
      if (p % DIV == DIV - 1) begin
        checkOutput("tbl_data", 32'(data), 32'((v.value >> (4 * slot)) & 16'hF));
        checkOutput("tbl_dot", 32'(dot), 32'(v.dots[slot]));
      end
    end
    for (int s = 0; s < N; s++)
      checkOutput("tbl_strobe_cycles", onCount[s], v.litMask[s] ? DIV - BLANK : 0);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0100, 4'b0000, 1'b0, 4'b1111};
    vecs[1] = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 4'b0011};
    vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 4'b0001};
    vecs[3] = '{16'hABCD, 4'b1001, 4'b0010, 1'b0, 4'b1101};
    vecs[4] = '{16'h0100, 4'b1111, 4'b0001, 1'b1, 4'b0110};
    vecs[5] = '{16'hF000, 4'b0010, 4'b0000, 1'b1, 4'b1111};

    // Reset values while held, then first frame after release.
    applyStimulus(16'h1234, 4'b0100, 4'b0000, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("first_frame_start", 32'(frameStart), 32'd1);
    tick();
    checkOutput("blank_after_release", 32'(digitSel), 32'hF);
    tick();
    checkOutput("digit0_on", 32'(digitSel), 32'hE);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) runVector(vecs[i]);

    // Mid-frame input change is ignored until the next boundary.
    runToBoundary();
    applyStimulus(16'h1111, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < DIV + 3; i++) tick();
    applyStimulus(16'h2222, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < FRAME && (p % FRAME) != FRAME - 1; i++) begin
      tick();
      if (p % DIV == DIV - 1) checkOutput("midframe_old", 32'(data), 32'h1);
    end
    tick();
    checkOutput("midframe_fs", 32'(frameStart), 32'd1);
    checkOutput("midframe_new", 32'(data), 32'h2);

    // Reset asserted during the lit part of digit 2.
    applyStimulus(16'h1234, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 2 * FRAME && !(((p / DIV) % N) == 2 && (p % DIV) == 4); i++) tick();
    checkOutput("digit2_lit", 32'(digitSel), 32'hB);
    #2;
    reset_n = 1'b0;
    #1;
    p = -1;
    checkOutput("async_reset_sel", 32'(digitSel), 32'hF);
    checkOutput("async_reset_data", 32'(data), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("restart_fs", 32'(frameStart), 32'd1);
    tick();
    tick();
    checkOutput("restart_digit0", 32'(digitSel), 32'hE);

    // Randomized inputs, changing at random points mid-frame.
    for (int i = 0; i < 20 * FRAME; i++) begin
      if ($urandom_range(7) == 0) begin
        logic [15:0] rv;
        for (int k = 0; k < N; k++)
          rv[4*k +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
        applyStimulus(rv, 4'($urandom), 4'($urandom & $urandom), 1'($urandom));
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
